// File: rtl/register_mem.sv
// 8 x 8 register file for the MIPS-Lite datapath: three combinational read ports, one write port.
// Optional build macro REG_ZERO_HARDWIRED_EN makes register 0 read as zero and ignore writes.
module register_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3,
    parameter logic [2:0]  SW_OP  = 3'b110
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        ALU_op,
    input  logic [ADDR_W-1:0] rs_in,
    input  logic [ADDR_W-1:0] rt_in,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic [DATA_W-1:0] from_reg_src,
    input  logic              reg_write,
    output logic [DATA_W-1:0] rs_out,
    output logic [DATA_W-1:0] rt_out,
    output logic [DATA_W-1:0] save_out
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

`ifdef REG_ZERO_HARDWIRED_EN
    localparam bit ZERO_HARDWIRED = 1'b1;
`else
    localparam bit ZERO_HARDWIRED = 1'b0;
`endif

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_en;

    // Stores reuse rd_in as the data source index, so they must never write back.
    assign wr_en = reg_write && (ALU_op != SW_OP);

    // Per-entry decode keeps an unknown index from touching any register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if ((rd_in == ADDR_W'(i)) && !(ZERO_HARDWIRED && (i == 0))) begin
                    regs[i] <= from_reg_src;
                end
            end
        end
    end

    // Read ports: no bypass, a same-cycle write shows up only after the edge.
    always_comb begin
        rs_out   = regs[rs_in];
        rt_out   = regs[rt_in];
        save_out = regs[rd_in];
        if (ZERO_HARDWIRED) begin
            if (rs_in == '0) rs_out   = '0;
            if (rt_in == '0) rt_out   = '0;
            if (rd_in == '0) save_out = '0;
        end
    end

endmodule

// File: tb/tb_register_mem.sv
// Bench for register_mem: directed steps followed by random traffic against an array model.
// Honours REG_ZERO_HARDWIRED_EN when the same macro is defined for the build.
module tb_register_mem;

`ifdef REG_ZERO_HARDWIRED_EN
    localparam bit HARDWIRED = 1'b1;
`else
    localparam bit HARDWIRED = 1'b0;
`endif

    logic       clk = 1'b1;
    logic       rst = 1'b0;
    logic [2:0] ALU_op = 3'd0;
    logic [2:0] rs_in = 3'd0;
    logic [2:0] rt_in = 3'd0;
    logic [2:0] rd_in = 3'd0;
    logic [7:0] from_reg_src = 8'd0;
    logic       reg_write = 1'b0;
    logic [7:0] rs_out, rt_out, save_out;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] model [8];

    register_mem dut (
        .clk          (clk),
        .rst          (rst),
        .ALU_op       (ALU_op),
        .rs_in        (rs_in),
        .rt_in        (rt_in),
        .rd_in        (rd_in),
        .from_reg_src (from_reg_src),
        .reg_write    (reg_write),
        .rs_out       (rs_out),
        .rt_out       (rt_out),
        .save_out     (save_out)
    );

    always #50 clk = ~clk;

    function automatic logic [7:0] expect_rd(input logic [2:0] idx);
        if (HARDWIRED && idx == 3'd0) return 8'd0;
        return model[idx];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Point the three read ports, let them settle, compare against the model.
    task automatic read_check(input string tag, input logic [2:0] rs, input logic [2:0] rt,
                              input logic [2:0] rd);
        rs_in = rs;
        rt_in = rt;
        rd_in = rd;
        #1;
        check({tag, ".rs"}, rs_out, expect_rd(rs));
        check({tag, ".rt"}, rt_out, expect_rd(rt));
        check({tag, ".save"}, save_out, expect_rd(rd));
    endtask

    // One clock edge with the given write request, then sample 1 unit later.
    task automatic write_edge(input logic [2:0] op, input logic [2:0] rd, input logic [7:0] data,
                              input logic we);
        ALU_op       = op;
        rd_in        = rd;
        from_reg_src = data;
        reg_write    = we;
        @(posedge clk);
        if (we && op != 3'b110 && !(HARDWIRED && rd == 3'd0)) model[rd] = data;
        #1;
        reg_write = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = 8'd0;
    endtask

    initial begin
        logic [2:0] r_rs, r_rt, r_rd, r_op;
        logic [7:0] r_data;
        logic       r_we;

        clear_model();

        // Reset pulse at t=3 for 2 units, between clock edges.
        #3 rst = 1'b1;
        #1;
        check("reset.during", rs_out, 8'd0);
        #1 rst = 1'b0;
        for (int i = 1; i < 8; i++) read_check("reset.sweep", 3'(i), 3'(i), 3'(i));

        // r1 <= 5; old value must be visible before the edge.
        ALU_op = 3'b000; rd_in = 3'd1; from_reg_src = 8'd5; reg_write = 1'b1; rs_in = 3'd1;
        #1;
        check("r1.pre_edge", rs_out, 8'd0);
        write_edge(3'b000, 3'd1, 8'd5, 1'b1);
        rs_in = 3'd1;
        #1;
        check("r1.post_edge", rs_out, 8'd5);

        write_edge(3'b000, 3'd2, 8'd4, 1'b1);
        write_edge(3'b010, 3'd3, 8'd20, 1'b1);
        read_check("r1_r2", 3'd1, 3'd2, 3'd3);
        check("r3.save_const", save_out, 8'd20);
        rs_in = 3'd3;
        #1;
        check("r3.rs_const", rs_out, 8'd20);

        // Write inhibits: enable low, then store opcode.
        write_edge(3'b000, 3'd1, 8'd99, 1'b0);
        read_check("inhibit.we", 3'd1, 3'd1, 3'd1);
        check("inhibit.we_const", rs_out, 8'd5);
        write_edge(3'b110, 3'd2, 8'd77, 1'b1);
        read_check("inhibit.sw", 3'd2, 3'd2, 3'd2);
        check("inhibit.sw_const", rt_out, 8'd4);

        // Register 0 behaviour depends on the build.
        write_edge(3'b000, 3'd0, 8'hAA, 1'b1);
        read_check("r0", 3'd0, 3'd0, 3'd0);
        check("r0.const", rs_out, HARDWIRED ? 8'h00 : 8'hAA);

        // Async reset mid-cycle; a write pending across the edge is dropped.
        write_edge(3'b000, 3'd4, 8'd55, 1'b1);
        #10 rst = 1'b1;
        clear_model();
        for (int i = 0; i < 8; i++) read_check("midrst", 3'(i), 3'(7 - i), 3'(i));
        ALU_op = 3'b000; rd_in = 3'd5; from_reg_src = 8'd66; reg_write = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        reg_write = 1'b0;
        read_check("midrst.drop", 3'd4, 3'd5, 3'd5);

        // Random traffic: check pre-edge (old values) and post-edge each cycle.
        for (int n = 0; n < 400; n++) begin
            r_op   = 3'($urandom_range(0, 7));
            r_rd   = 3'($urandom_range(0, 7));
            r_data = 8'($urandom);
            r_we   = ($urandom_range(0, 3) != 0);
            r_rs   = ($urandom_range(0, 3) == 0) ? r_rd : 3'($urandom_range(0, 7));
            r_rt   = 3'($urandom_range(0, 7));
            ALU_op = r_op; from_reg_src = r_data; reg_write = r_we;
            read_check("rand.pre", r_rs, r_rt, r_rd);
            write_edge(r_op, r_rd, r_data, r_we);
            read_check("rand.post", r_rs, r_rt, r_rd);
            if ($urandom_range(0, 39) == 0) begin
                reg_write = 1'b1; ALU_op = 3'b000; from_reg_src = 8'($urandom) | 8'h01;
                #5 rst = 1'b1;
                clear_model();
                read_check("rand.rst", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                           3'($urandom_range(0, 7)));
                @(posedge clk);
                #1 rst = 1'b0;
                reg_write = 1'b0;
                read_check("rand.rst_after", r_rs, r_rt, r_rd);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
